// File: rtl/rc5_frame_rx_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rc5_frame_rx_if                                           |
// | Purpose  : Result bundle of the RC5 frame receiver. It carries the   |
// |            decoded frame together with its status strobes.           |
// | Signals  : frame[13:0] - last good frame, [13]=S1 ... [0]=cmd LSB    |
// |            valid       - one-cycle strobe, frame updated             |
// |            new_press   - toggle changed / first frame (with valid)   |
// |            err         - one-cycle Manchester violation strobe       |
// |            busy        - frame sampling in progress                  |
// | Modports : master (receiver drives), slave (consumer reads)          |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface rc5_frame_rx_if;
  logic [13:0] frame;
  logic        valid;
  logic        new_press;
  logic        err;
  logic        busy;

  modport master (output frame, valid, new_press, err, busy);
  modport slave  (input  frame, valid, new_press, err, busy);
endinterface
`default_nettype wire

// File: rtl/rc5_frame_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rc5_frame_rx                                              |
// | Purpose  : RC5 infrared front end. Synchronises the raw receiver     |
// |            pin and decodes one 14-bit Manchester frame at a time.    |
// | Ports    : clk    - system clock, rising edge                        |
// |            rst    - asynchronous reset, active low                   |
// |            i_rc5  - raw IR receiver pin (idle high, burst low)       |
// |            rx     - result bundle (frame/valid/new_press/err/busy)   |
// | Params   : HALF_BIT - clock cycles per RC5 half-bit, even and >= 4   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module rc5_frame_rx #(
  parameter int HALF_BIT = 16
) (
  input  wire            clk,
  input  wire            rst,
  input  wire            i_rc5,
  rc5_frame_rx_if.master rx
);

  localparam int                 c_cnt_w     = $clog2(HALF_BIT);
  localparam logic [c_cnt_w-1:0] c_mid       = c_cnt_w'(HALF_BIT / 2);
  localparam logic [c_cnt_w-1:0] c_last_cnt  = c_cnt_w'(HALF_BIT - 1);
  localparam logic [4:0]         c_last_slot = 5'd26;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Synchroniser and edge-detect history
  logic sync1_q, sync2_q, prev_q;

  // Sequencer state
  state_t             state_q,     state_d;
  logic [c_cnt_w-1:0] cnt_q,       cnt_d;
  logic [4:0]         slot_q,      slot_d;
  logic               first_q,     first_d;
  logic [13:0]        sr_q,        sr_d;

  // Registered outputs and key-press history
  logic [13:0]        frame_q,     frame_d;
  logic               valid_q,     valid_d;
  logic               new_press_q, new_press_d;
  logic               err_q,       err_d;
  logic               busy_q,      busy_d;
  logic               toggle_q,    toggle_d;
  logic               seen_q,      seen_d;

  logic               w_fall;
  logic               w_sample;
  logic [13:0]        w_shifted;

  assign w_fall    = prev_q & ~sync2_q;
  // Slot 0 is the second half of S1, whose value is implied by the start edge.
  assign w_sample  = (cnt_q == c_mid) && (slot_q != 5'd0);
  // A low second half encodes a 1.
  assign w_shifted = {sr_q[12:0], ~sync2_q};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    slot_d      = slot_q;
    first_d     = first_q;
    sr_d        = sr_q;
    frame_d     = frame_q;
    valid_d     = 1'b0;
    new_press_d = 1'b0;
    err_d       = 1'b0;
    busy_d      = busy_q;
    toggle_d    = toggle_q;
    seen_d      = seen_q;

    case (state_q)
      ST_IDLE: begin
        // The falling edge is mid-bit of S1, so S1 is seeded as 1.
        if (w_fall) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          slot_d  = 5'd0;
          sr_d    = 14'd1;
          busy_d  = 1'b1;
        end
      end

      ST_RUN: begin
        if (cnt_q == c_last_cnt) begin
          cnt_d  = '0;
          slot_d = slot_q + 5'd1;
        end else begin
          cnt_d  = cnt_q + c_cnt_w'(1);
        end

        if (w_sample) begin
          if (slot_q[0]) begin
            // First half of a bit: keep it for the pairing check.
            first_d = sync2_q;
          end else if (first_q == sync2_q) begin
            // No mid-bit transition: not a Manchester symbol.
            err_d   = 1'b1;
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end else begin
            sr_d = w_shifted;
            if (slot_q == c_last_slot) begin
              frame_d     = w_shifted;
              valid_d     = 1'b1;
              new_press_d = ~seen_q | (w_shifted[11] != toggle_q);
              toggle_d    = w_shifted[11];
              seen_d      = 1'b1;
              state_d     = ST_IDLE;
              busy_d      = 1'b0;
            end
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      prev_q      <= 1'b1;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      slot_q      <= 5'd0;
      first_q     <= 1'b0;
      sr_q        <= 14'd0;
      frame_q     <= 14'd0;
      valid_q     <= 1'b0;
      new_press_q <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      toggle_q    <= 1'b0;
      seen_q      <= 1'b0;
    end else begin
      sync1_q     <= i_rc5;
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      slot_q      <= slot_d;
      first_q     <= first_d;
      sr_q        <= sr_d;
      frame_q     <= frame_d;
      valid_q     <= valid_d;
      new_press_q <= new_press_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      toggle_q    <= toggle_d;
      seen_q      <= seen_d;
    end
  end

  assign rx.frame     = frame_q;
  assign rx.valid     = valid_q;
  assign rx.new_press = new_press_q;
  assign rx.err       = err_q;
  assign rx.busy      = busy_q;

endmodule
`default_nettype wire
